// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizes for the data-memory arbiter.
// Round-robin contention policy is enabled by defining DMEM_ARB_RR_EN.
package dmem_arb_pkg;

   localparam int unsigned DM_ADDRESS_DEF = 9;
   localparam int unsigned DATA_W_DEF     = 32;
   localparam int unsigned MAX_LEN_W_DEF  = 4;

   typedef enum logic {
      IDLE,
      EXT_BURST
   } arb_state_t;

   typedef enum logic {
      OWN_CPU,
      OWN_EXT
   } owner_t;

endpackage

// File: rtl/dmem_arb_burst_gen.sv
// Burst beat counter for the external port: holds base/length, produces the
// wrapped beat address and flags the final beat.
module dmem_arb_burst_gen
   import dmem_arb_pkg::*;
#(
   parameter int unsigned DM_ADDRESS = DM_ADDRESS_DEF,
   parameter int unsigned MAX_LEN_W  = MAX_LEN_W_DEF
)
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load,
   input  logic                  step,
   input  logic [DM_ADDRESS-1:0] base,
   input  logic [MAX_LEN_W-1:0]  len,
   output logic [DM_ADDRESS-1:0] addr,
   output logic                  last
);

   logic [DM_ADDRESS-1:0] base_q;
   logic [MAX_LEN_W-1:0]  len_q;
   logic [MAX_LEN_W-1:0]  beat_q;

   // Beat 0 is issued by the arbiter directly from ext_addr, so a loaded
   // burst resumes at beat 1.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         base_q <= '0;
         len_q  <= '0;
         beat_q <= '0;
      end else if (load) begin
         base_q <= base;
         len_q  <= len;
         beat_q <= MAX_LEN_W'(1);
      end else if (step) begin
         beat_q <= last ? '0 : beat_q + MAX_LEN_W'(1);
      end
   end

   assign addr = base_q + DM_ADDRESS'(beat_q);
   assign last = (beat_q == len_q);

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter between CPU load/store and an external burst
// port. Define DMEM_ARB_RR_EN for round-robin contention, else CPU has priority.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned DM_ADDRESS = DM_ADDRESS_DEF,
   parameter int unsigned DATA_W     = DATA_W_DEF,
   parameter int unsigned MAX_LEN_W  = MAX_LEN_W_DEF
)
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cpu_req,
   input  logic                  cpu_we,
   input  logic [DM_ADDRESS-1:0] cpu_addr,
   input  logic [DATA_W-1:0]     cpu_wdata,
   output logic                  cpu_gnt,
   output logic                  cpu_rvalid,
   output logic [DATA_W-1:0]     cpu_rdata,
   input  logic                  ext_req,
   input  logic                  ext_we,
   input  logic [DM_ADDRESS-1:0] ext_addr,
   input  logic [MAX_LEN_W-1:0]  ext_len,
   input  logic [DATA_W-1:0]     ext_wdata,
   output logic                  ext_gnt,
   output logic                  ext_rvalid,
   output logic [DATA_W-1:0]     ext_rdata,
   output logic                  ext_done,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [DM_ADDRESS-1:0] mem_a,
   output logic [DATA_W-1:0]     mem_wd,
   input  logic [DATA_W-1:0]     mem_rd
);

   arb_state_t            state_q, state_d;
   owner_t                last_owner_q;
   logic                  burst_we_q;
   logic                  prefer_cpu;
   logic                  cpu_win, ext_win;
   logic                  load, step, done_d;
   logic                  last_beat;
   logic [DM_ADDRESS-1:0] burst_addr;

   dmem_arb_burst_gen #(
      .DM_ADDRESS (DM_ADDRESS),
      .MAX_LEN_W  (MAX_LEN_W)
   ) u_burst_gen (
      .clk   (clk),
      .reset (reset),
      .load  (load),
      .step  (step),
      .base  (ext_addr),
      .len   (ext_len),
      .addr  (burst_addr),
      .last  (last_beat)
   );

`ifdef DMEM_ARB_RR_EN
   assign prefer_cpu = (last_owner_q == OWN_EXT);
`else
   // Fixed priority: always true; last_owner is still tracked in this build.
   assign prefer_cpu = (last_owner_q == OWN_EXT) || (last_owner_q == OWN_CPU);
`endif

   // No new grants while reset is held, so an aborted burst stops at once.
   assign cpu_win = cpu_req && !reset && (!ext_req || prefer_cpu);
   assign ext_win = ext_req && !reset && !cpu_win;

   always_comb begin
      state_d   = state_q;
      cpu_gnt   = 1'b0;
      ext_gnt   = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_a     = '0;
      mem_wd    = '0;
      load      = 1'b0;
      step      = 1'b0;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (cpu_win) begin
               cpu_gnt   = 1'b1;
               mem_read  = !cpu_we;
               mem_write = cpu_we;
               mem_a     = cpu_addr;
               mem_wd    = cpu_wdata;
            end else if (ext_win) begin
               ext_gnt   = 1'b1;
               mem_read  = !ext_we;
               mem_write = ext_we;
               mem_a     = ext_addr;
               mem_wd    = ext_wdata;
               if (ext_len != '0) begin
                  load    = 1'b1;
                  state_d = EXT_BURST;
               end else begin
                  done_d  = 1'b1;
               end
            end
         end
         EXT_BURST: begin
            ext_gnt   = 1'b1;
            mem_read  = !burst_we_q;
            mem_write = burst_we_q;
            mem_a     = burst_addr;
            mem_wd    = ext_wdata;
            step      = 1'b1;
            if (last_beat) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         last_owner_q <= OWN_EXT;
         burst_we_q   <= 1'b0;
         cpu_rvalid   <= 1'b0;
         cpu_rdata    <= '0;
         ext_rvalid   <= 1'b0;
         ext_rdata    <= '0;
         ext_done     <= 1'b0;
      end else begin
         state_q    <= state_d;
         ext_done   <= done_d;
         cpu_rvalid <= cpu_gnt && mem_read;
         ext_rvalid <= ext_gnt && mem_read;
         if (cpu_gnt && mem_read)
            cpu_rdata <= mem_rd;
         if (ext_gnt && mem_read)
            ext_rdata <= mem_rd;
         if (load)
            burst_we_q <= ext_we;
         if (cpu_gnt)
            last_owner_q <= OWN_CPU;
         else if (state_q == IDLE && ext_gnt)
            last_owner_q <= OWN_EXT;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural memory.
// Expectations follow DMEM_ARB_RR_EN when it is defined for the build.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_req, cpu_we;
   logic [8:0]  cpu_addr;
   logic [31:0] cpu_wdata;
   logic        cpu_gnt, cpu_rvalid;
   logic [31:0] cpu_rdata;
   logic        ext_req, ext_we;
   logic [8:0]  ext_addr;
   logic [3:0]  ext_len;
   logic [31:0] ext_wdata;
   logic        ext_gnt, ext_rvalid, ext_done;
   logic [31:0] ext_rdata;
   logic        mem_read, mem_write;
   logic [8:0]  mem_a;
   logic [31:0] mem_wd, mem_rd;

   logic [31:0] mem [512];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign mem_rd = mem[mem_a];
   always @(posedge clk)
      if (mem_write) mem[mem_a] <= mem_wd;

   dmem_arbiter #(
      .DM_ADDRESS (9),
      .DATA_W     (32),
      .MAX_LEN_W  (4)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_gnt    (cpu_gnt),
      .cpu_rvalid (cpu_rvalid),
      .cpu_rdata  (cpu_rdata),
      .ext_req    (ext_req),
      .ext_we     (ext_we),
      .ext_addr   (ext_addr),
      .ext_len    (ext_len),
      .ext_wdata  (ext_wdata),
      .ext_gnt    (ext_gnt),
      .ext_rvalid (ext_rvalid),
      .ext_rdata  (ext_rdata),
      .ext_done   (ext_done),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .mem_a      (mem_a),
      .mem_wd     (mem_wd),
      .mem_rd     (mem_rd)
   );

   task automatic idle_inputs();
      cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
      ext_req = 0; ext_we = 0; ext_addr = '0; ext_len = '0; ext_wdata = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      idle_inputs();
      reset = 1;
      @(negedge clk);
      reset = 0;
   endtask

   task automatic cpu_wr(input logic [8:0] a, input logic [31:0] d);
      @(negedge clk);
      cpu_req = 1; cpu_we = 1; cpu_addr = a; cpu_wdata = d;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1;
      @(negedge clk); #1;
      checks++;
      if ({cpu_gnt, cpu_rvalid, ext_gnt, ext_rvalid, ext_done, mem_read, mem_write} !== 7'b0) begin
         errors++;
         $display("FAIL reset_flags: got %b exp 0000000",
                  {cpu_gnt, cpu_rvalid, ext_gnt, ext_rvalid, ext_done, mem_read, mem_write});
      end
      checks++;
      if ({cpu_rdata, ext_rdata} !== 64'h0) begin
         errors++;
         $display("FAIL reset_rdata: got cpu %h ext %h exp 0", cpu_rdata, ext_rdata);
      end
      checks++;
      if ({mem_a, mem_wd} !== 41'h0) begin
         errors++;
         $display("FAIL reset_mem_bus: got a %h wd %h exp 0", mem_a, mem_wd);
      end
      @(negedge clk);
      reset = 0;
   endtask

   task automatic test_cpu_rw();
      @(negedge clk);
      cpu_req = 1; cpu_we = 1; cpu_addr = 9'h010; cpu_wdata = 32'hDEADBEEF;
      #1;
      checks++;
      if ({cpu_gnt, mem_write, mem_read, mem_a, mem_wd} !== {3'b110, 9'h010, 32'hDEADBEEF}) begin
         errors++;
         $display("FAIL cpu_write: got gnt %b we %b re %b a %h wd %h", cpu_gnt, mem_write, mem_read, mem_a, mem_wd);
      end
      @(negedge clk);
      cpu_we = 0;
      #1;
      checks++;
      if ({cpu_gnt, mem_read, mem_write, cpu_rvalid, mem_a} !== {4'b1100, 9'h010}) begin
         errors++;
         $display("FAIL cpu_read_issue: got gnt %b re %b we %b rv %b a %h", cpu_gnt, mem_read, mem_write, cpu_rvalid, mem_a);
      end
      @(negedge clk);
      cpu_req = 0;
      #1;
      checks++;
      if ({cpu_rvalid, cpu_rdata} !== {1'b1, 32'hDEADBEEF}) begin
         errors++;
         $display("FAIL cpu_read_data: got rv %b data %h exp 1 deadbeef", cpu_rvalid, cpu_rdata);
      end
      checks++;
      if ({ext_gnt, ext_rvalid, ext_done, ext_rdata} !== 35'h0) begin
         errors++;
         $display("FAIL cpu_ext_quiet: got gnt %b rv %b done %b data %h exp 0", ext_gnt, ext_rvalid, ext_done, ext_rdata);
      end
   endtask

   task automatic test_ext_read_burst();
      logic [8:0]  exp_a [4];
      logic [31:0] exp_d [4];
      exp_a = '{9'h1FE, 9'h1FF, 9'h000, 9'h001};
      exp_d = '{32'hA0A0_0000, 32'hA1A1_1111, 32'hA2A2_2222, 32'hA3A3_3333};
      for (int i = 0; i < 4; i++) cpu_wr(exp_a[i], exp_d[i]);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         cpu_req = 0; cpu_we = 0;
         if (i == 0) begin
            ext_req = 1; ext_we = 0; ext_addr = 9'h1FE; ext_len = 4'd3;
         end else begin
            // Mid-burst control inputs must be ignored.
            ext_req = 0; ext_we = 1; ext_addr = 9'h123; ext_len = 4'd0;
         end
         #1;
         checks++;
         if ({ext_gnt, cpu_gnt, mem_read, mem_write, mem_a} !== {4'b1010, exp_a[i]}) begin
            errors++;
            $display("FAIL ext_rd_beat%0d: got gnt %b re %b we %b a %h exp a %h", i, ext_gnt, mem_read, mem_write, mem_a, exp_a[i]);
         end
         if (i > 0) begin
            checks++;
            if ({ext_rvalid, ext_done, ext_rdata} !== {2'b10, exp_d[i-1]}) begin
               errors++;
               $display("FAIL ext_rd_data%0d: got rv %b done %b data %h exp 1 0 %h", i, ext_rvalid, ext_done, ext_rdata, exp_d[i-1]);
            end
         end
      end
      @(negedge clk);
      idle_inputs();
      #1;
      checks++;
      if ({ext_gnt, mem_read, ext_rvalid, ext_done, ext_rdata} !== {4'b0011, exp_d[3]}) begin
         errors++;
         $display("FAIL ext_rd_done: got gnt %b re %b rv %b done %b data %h", ext_gnt, mem_read, ext_rvalid, ext_done, ext_rdata);
      end
      @(negedge clk); #1;
      checks++;
      if ({ext_rvalid, ext_done, ext_rdata} !== {2'b00, exp_d[3]}) begin
         errors++;
         $display("FAIL ext_rd_after: got rv %b done %b data %h", ext_rvalid, ext_done, ext_rdata);
      end
   endtask

   task automatic test_contention();
      logic exp_cpu;
      do_reset();
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         cpu_req = 1; cpu_we = 0; cpu_addr = 9'h010;
         ext_req = 1; ext_we = 0; ext_addr = 9'h1FE; ext_len = 4'd0;
         #1;
`ifdef DMEM_ARB_RR_EN
         exp_cpu = (c % 2 == 0);
`else
         exp_cpu = 1'b1;
`endif
         checks++;
         if ({cpu_gnt, ext_gnt, mem_a} !== {exp_cpu, !exp_cpu, exp_cpu ? 9'h010 : 9'h1FE}) begin
            errors++;
            $display("FAIL contention%0d: got cpu %b ext %b a %h exp cpu %b", c, cpu_gnt, ext_gnt, mem_a, exp_cpu);
         end
      end
      @(negedge clk);
      idle_inputs();
      #1;
      checks++;
`ifdef DMEM_ARB_RR_EN
      if ({cpu_rvalid, ext_rvalid, ext_done, ext_rdata} !== {3'b011, 32'hA0A0_0000}) begin
`else
      if ({cpu_rvalid, ext_rvalid, ext_done, cpu_rdata} !== {3'b100, 32'hDEADBEEF}) begin
`endif
         errors++;
         $display("FAIL contention_tail: got crv %b erv %b done %b cdata %h edata %h",
                  cpu_rvalid, ext_rvalid, ext_done, cpu_rdata, ext_rdata);
      end
   endtask

   task automatic test_cpu_wait_burst();
      @(negedge clk);
      cpu_req = 0;
      ext_req = 1; ext_we = 0; ext_addr = 9'h100; ext_len = 4'd7;
      #1;
      checks++;
      if ({ext_gnt, mem_a} !== {1'b1, 9'h100}) begin
         errors++;
         $display("FAIL wait_beat0: got gnt %b a %h exp 1 100", ext_gnt, mem_a);
      end
      for (int b = 1; b < 8; b++) begin
         @(negedge clk);
         ext_req = 0;
         cpu_req = 1; cpu_we = 0; cpu_addr = 9'h011;
         #1;
         checks++;
         if ({cpu_gnt, ext_gnt, mem_a} !== {2'b01, 9'h100 + 9'(b)}) begin
            errors++;
            $display("FAIL wait_beat%0d: got cpu %b ext %b a %h", b, cpu_gnt, ext_gnt, mem_a);
         end
      end
      @(negedge clk); #1;
      checks++;
      if ({cpu_gnt, ext_gnt, ext_done, mem_a} !== {3'b101, 9'h011}) begin
         errors++;
         $display("FAIL wait_cpu_after: got cpu %b ext %b done %b a %h", cpu_gnt, ext_gnt, ext_done, mem_a);
      end
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic test_ext_write_burst();
      @(negedge clk);
      ext_req = 1; ext_we = 1; ext_addr = 9'h040; ext_len = 4'd1; ext_wdata = 32'h11;
      #1;
      checks++;
      if ({ext_gnt, mem_write, mem_read, mem_a, mem_wd} !== {3'b110, 9'h040, 32'h11}) begin
         errors++;
         $display("FAIL ext_wr_beat0: got gnt %b we %b re %b a %h wd %h", ext_gnt, mem_write, mem_read, mem_a, mem_wd);
      end
      @(negedge clk);
      ext_req = 0; ext_we = 0; ext_wdata = 32'h22;
      #1;
      checks++;
      if ({ext_gnt, mem_write, mem_read, ext_rvalid, mem_a, mem_wd} !== {4'b1100, 9'h041, 32'h22}) begin
         errors++;
         $display("FAIL ext_wr_beat1: got gnt %b we %b re %b rv %b a %h wd %h", ext_gnt, mem_write, mem_read, ext_rvalid, mem_a, mem_wd);
      end
      @(negedge clk);
      ext_wdata = '0;
      cpu_req = 1; cpu_we = 0; cpu_addr = 9'h040;
      #1;
      checks++;
      if ({ext_done, ext_rvalid, cpu_gnt} !== 3'b101) begin
         errors++;
         $display("FAIL ext_wr_done: got done %b rv %b cpu_gnt %b exp 101", ext_done, ext_rvalid, cpu_gnt);
      end
      @(negedge clk);
      cpu_addr = 9'h041;
      #1;
      checks++;
      if ({cpu_rvalid, cpu_rdata} !== {1'b1, 32'h11}) begin
         errors++;
         $display("FAIL ext_wr_rb0: got rv %b data %h exp 1 00000011", cpu_rvalid, cpu_rdata);
      end
      @(negedge clk);
      idle_inputs();
      #1;
      checks++;
      if ({cpu_rvalid, cpu_rdata} !== {1'b1, 32'h22}) begin
         errors++;
         $display("FAIL ext_wr_rb1: got rv %b data %h exp 1 00000022", cpu_rvalid, cpu_rdata);
      end
   endtask

   task automatic test_reset_mid_burst();
      @(negedge clk);
      ext_req = 1; ext_we = 0; ext_addr = 9'h080; ext_len = 4'd5;
      @(negedge clk);
      ext_req = 0;
      #1;
      checks++;
      if ({ext_gnt, mem_a} !== {1'b1, 9'h081}) begin
         errors++;
         $display("FAIL rst_burst_beat1: got gnt %b a %h exp 1 081", ext_gnt, mem_a);
      end
      @(negedge clk);
      reset = 1;
      #1;
      checks++;
      if ({mem_read, mem_write, ext_gnt} !== 3'b000) begin
         errors++;
         $display("FAIL rst_burst_abort: got re %b we %b gnt %b exp 000", mem_read, mem_write, ext_gnt);
      end
      @(negedge clk);
      reset = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); #1;
         checks++;
         if ({ext_done, ext_rvalid, ext_gnt, mem_read, mem_write} !== 5'b0) begin
            errors++;
            $display("FAIL rst_burst_quiet%0d: got done %b rv %b gnt %b re %b we %b", k, ext_done, ext_rvalid, ext_gnt, mem_read, mem_write);
         end
      end
      @(negedge clk);
      cpu_req = 1; cpu_we = 0; cpu_addr = 9'h010;
      #1;
      checks++;
      if ({cpu_gnt, ext_gnt} !== 2'b10) begin
         errors++;
         $display("FAIL rst_burst_idle: got cpu %b ext %b exp 10", cpu_gnt, ext_gnt);
      end
      @(negedge clk);
      idle_inputs();
      #1;
      checks++;
      if ({cpu_rvalid, cpu_rdata} !== {1'b1, 32'hDEADBEEF}) begin
         errors++;
         $display("FAIL rst_burst_cpu_rd: got rv %b data %h exp 1 deadbeef", cpu_rvalid, cpu_rdata);
      end
   endtask

   initial begin
      test_reset();
      test_cpu_rw();
      test_ext_read_burst();
      test_contention();
      test_cpu_wait_burst();
      test_ext_write_burst();
      test_reset_mid_burst();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port data memory (2^DM_ADDRESS words x DATA_W) between the processor load/store path and an external burst port (debug/DMA loader). Issues at most one memory access per cycle, drives the memory's MemRead/MemWrite/address/write-data inputs, and returns read data to the owning requester one cycle after the access. Sits between the execute stage / external loader and the data memory.

## Interface
- DM_ADDRESS, 9, word address width
- DATA_W, 32, data width
- MAX_LEN_W, 4, burst length field width (max 2^MAX_LEN_W beats)

- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- cpu_req  in  1  CPU access request
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  DM_ADDRESS  word address
- cpu_wdata  in  DATA_W  write data
- cpu_gnt  out  1  access performed this cycle (combinational)
- cpu_rvalid  out  1  cpu_rdata valid (read only)
- cpu_rdata  out  DATA_W  registered read data
- ext_req  in  1  burst request
- ext_we  in  1  burst direction
- ext_addr  in  DM_ADDRESS  burst base address
- ext_len  in  MAX_LEN_W  beats minus one
- ext_wdata  in  DATA_W  write data, sampled every beat with ext_gnt
- ext_gnt  out  1  beat performed this cycle
- ext_rvalid  out  1  ext_rdata valid
- ext_rdata  out  DATA_W  registered read data
- ext_done  out  1  one-cycle pulse after last beat
- mem_read, mem_write  out  1 each  to memory MemRead/MemWrite
- mem_a  out  DM_ADDRESS  to memory address
- mem_wd  out  DATA_W  to memory write data
- mem_rd  in  DATA_W  combinational memory read data

## Operation
- States: IDLE, EXT_BURST.
- IDLE: arbitrate cpu_req vs ext_req every cycle. Sole requester wins. Both: policy per Configuration. Winner's access is issued in the same cycle.
- CPU win: cpu_gnt=1, mem_* from cpu_* ; stay IDLE. CPU may win on consecutive cycles.
- EXT win: beat 0 issued from ext_addr; capture ext_we, ext_addr, ext_len. If ext_len=0 stay IDLE, else go EXT_BURST with beat counter=1.
- EXT_BURST: one beat per cycle, mem_a = (base + beat) mod 2^DM_ADDRESS (wraps 511->0), ext_gnt=1, cpu_gnt=0. After beat == len, return to IDLE. ext_req/ext_we/ext_addr/ext_len ignored mid-burst; ext_wdata sampled every beat.
- Read beats: mem_rd captured into owner's rdata register; rvalid high next cycle. Write beats: no rvalid.
- ext_done: high the cycle after the last beat, read or write.
- No access: mem_read=mem_write=0, mem_a=0, mem_wd=0.
- last_owner register updated on every grant (CPU or EXT beat 0).

## Timing
- Reset values: state IDLE, cpu_rvalid/ext_rvalid/ext_done 0, cpu_rdata/ext_rdata 0, last_owner=EXT, beat counter 0; combinational outputs therefore 0 with no request.
- Read latency: grant cycle N, rvalid/rdata cycle N+1; rdata holds until next read for that requester.
- Write then read same address on next cycle returns new data.
- Burst of L+1 beats occupies cycles N..N+L; ext_done at N+L+1; earliest next arbitration N+L+1.
- CPU worst-case wait: 2^MAX_LEN_W cycles (one full burst).
- Reset mid-burst: burst aborted, no ext_done, no further mem accesses.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin on contention; requester not equal to last_owner wins (first contention after reset: CPU).
- Undefined: fixed priority, CPU always wins contention in IDLE; last_owner still maintained but unused.

## Structure
- Package dmem_arb_pkg: state enum (IDLE, EXT_BURST), owner enum (OWN_CPU, OWN_EXT), default DM_ADDRESS/DATA_W/MAX_LEN_W constants.
- One sub-module dmem_arb_burst_gen: beat counter, wrapped address generation, last-beat flag.

## Test plan
- CPU write 0xDEADBEEF @0x010, then read @0x010 -> cpu_gnt both cycles, cpu_rvalid next cycle with 0xDEADBEEF, ext_* stay 0.
- EXT read burst addr 0x1FE, len 3 -> mem_a 0x1FE,0x1FF,0x000,0x001 on consecutive cycles, 4 ext_rvalid, ext_done 1 cycle after beat 3.
- cpu_req and ext_req both high for 6 cycles, len 0: RR_EN -> grants CPU,EXT,CPU,EXT,...; without -> CPU every cycle, ext_gnt never.
- CPU request during len 7 burst -> cpu_gnt 0 for remaining beats, granted first cycle after burst end.
- EXT write burst len 1 of 0x11,0x22 @0x040 then CPU reads 0x040/0x041 -> 0x11, 0x22.
- Reset asserted at beat 2 of len 5 burst -> mem_read/mem_write 0 immediately, no ext_done, state IDLE after release.
